// File: rtl/halton_seq_pkg.sv
// Shared types and constants for the Halton sequence driver and its result buffer.
package halton_seq_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_ISSUE     = 2'b01,
        ST_WAIT_DONE = 2'b10,
        ST_FINISH    = 2'b11
    } state_t;

    // Base selection codes understood by the Halton core
    localparam logic [1:0] BASE_SEL_2 = 2'b00;
    localparam logic [1:0] BASE_SEL_3 = 2'b01;
    localparam logic [1:0] BASE_SEL_7 = 2'b10;

    // 16.16 fixed-point result format
    localparam int FIX_W    = 32;
    localparam int FIX_FRAC = 16;

    // Index width and buffered entry layout {k, x, y}
    localparam int K_W     = 32;
    localparam int ENTRY_W = K_W + 2 * FIX_W;

    localparam int FIFO_DEPTH_DEF = 4;

    // Pack one result point into a buffer entry
    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic [K_W-1:0]   k,
        input logic [FIX_W-1:0] x,
        input logic [FIX_W-1:0] y
    );
        return {k, x, y};
    endfunction

endpackage

// File: rtl/halton_result_fifo.sv
// Result buffer: power-of-two circular FIFO of {k, x, y} entries with occupancy count.
module halton_result_fifo
    import halton_seq_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic [ENTRY_W-1:0] head_data,
    output logic               empty,
    output logic               full,
    output logic [CNT_W-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               push_ok_s;
    logic               pop_ok_s;

    // Guard against overflow/underflow at the buffer boundary
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage, pointers and occupancy; memory is cleared so the head reads zero out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign empty     = (count_r == CNT_W'(0));
    assign full      = (count_r == CNT_W'(DEPTH));
    assign count     = count_r;

endmodule

// File: rtl/halton_seq_driver.sv
// Halton sequence driver: issues indices to a Halton core one at a time and
// streams the buffered {k, x, y} results out over a valid/ready interface.
module halton_seq_driver
    import halton_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic [K_W-1:0]   cfg_k_start,
    input  logic [31:0]      cfg_count,
    input  logic [1:0]       cfg_base0_sel,
    input  logic [1:0]       cfg_base1_sel,
    output logic             busy,
    output logic             seq_done,
    output logic             core_start,
    output logic [K_W-1:0]   core_k,
    output logic [1:0]       core_base0_sel,
    output logic [1:0]       core_base1_sel,
    input  logic [FIX_W-1:0] core_result_x,
    input  logic [FIX_W-1:0] core_result_y,
    input  logic             core_done,
    input  logic             core_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [K_W-1:0]   out_k,
    output logic [FIX_W-1:0] out_x,
    output logic [FIX_W-1:0] out_y
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t             state_r;
    logic [K_W-1:0]     k_r;
    logic [31:0]        remaining_r;
    logic [1:0]         base0_r;
    logic [1:0]         base1_r;

    logic               issue_ok_s;
    logic               capture_s;
    logic               push_s;
    logic               pop_s;
    logic               fifo_empty_s;
    logic               fifo_full_s;
    logic [CNT_W-1:0]   fifo_count_s;
    logic [ENTRY_W-1:0] head_s;

    // Issue only with a free slot, which stays reserved because at most one result is outstanding.
    // core_done seen in the start cycle itself belongs to an earlier computation and is ignored.
    assign issue_ok_s = core_ready && (fifo_count_s < CNT_W'(FIFO_DEPTH));
    assign capture_s  = (state_r == ST_WAIT_DONE) && core_done && !core_start;
    assign push_s     = capture_s && !fifo_full_s;
    assign pop_s      = !fifo_empty_s && out_ready;

    // Sequencer FSM with registered control outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            k_r            <= '0;
            remaining_r    <= 32'd0;
            base0_r        <= BASE_SEL_2;
            base1_r        <= BASE_SEL_2;
            busy           <= 1'b0;
            seq_done       <= 1'b0;
            core_start     <= 1'b0;
            core_k         <= '0;
            core_base0_sel <= 2'b00;
            core_base1_sel <= 2'b00;
        end else begin
            core_start <= 1'b0;
            seq_done   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cfg_start) begin
                        k_r         <= cfg_k_start;
                        remaining_r <= cfg_count;
                        base0_r     <= cfg_base0_sel;
                        base1_r     <= cfg_base1_sel;
                        busy        <= 1'b1;
                        state_r     <= (cfg_count == 32'd0) ? ST_FINISH : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (issue_ok_s) begin
                        core_start     <= 1'b1;
                        core_k         <= k_r;
                        core_base0_sel <= base0_r;
                        core_base1_sel <= base1_r;
                        state_r        <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (capture_s) begin
                        k_r         <= k_r + 32'd1;
                        remaining_r <= remaining_r - 32'd1;
                        state_r     <= (remaining_r == 32'd1) ? ST_FINISH : ST_ISSUE;
                    end
                end
                ST_FINISH: begin
                    seq_done <= 1'b1;
                    busy     <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    halton_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (pack_entry(k_r, core_result_x, core_result_y)),
        .pop       (pop_s),
        .head_data (head_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s),
        .count     (fifo_count_s)
    );

    assign out_valid = !fifo_empty_s;
    assign out_k     = head_s[ENTRY_W-1 -: K_W];
    assign out_x     = head_s[2*FIX_W-1 -: FIX_W];
    assign out_y     = head_s[FIX_W-1:0];

endmodule

// File: tb/tb_halton_seq_driver.sv
// Self-checking bench for halton_seq_driver: behavioural Halton core, random
// stream consumer, and a reference list of expected points built from k and bases.
module tb_halton_seq_driver;

    typedef struct packed {
        logic [31:0] k;
        logic [31:0] x;
        logic [31:0] y;
    } pt_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_start = 1'b0;
    logic [31:0] cfg_k_start = 32'd0;
    logic [31:0] cfg_count = 32'd0;
    logic [1:0]  cfg_base0_sel = 2'b00;
    logic [1:0]  cfg_base1_sel = 2'b00;
    logic        busy, seq_done, core_start;
    logic [31:0] core_k;
    logic [1:0]  core_base0_sel, core_base1_sel;
    logic [31:0] core_result_x = 32'd0;
    logic [31:0] core_result_y = 32'd0;
    logic        core_done = 1'b0;
    logic        core_ready = 1'b1;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_k, out_x, out_y;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    halton_seq_driver #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_k_start(cfg_k_start),
        .cfg_count(cfg_count), .cfg_base0_sel(cfg_base0_sel), .cfg_base1_sel(cfg_base1_sel),
        .busy(busy), .seq_done(seq_done), .core_start(core_start), .core_k(core_k),
        .core_base0_sel(core_base0_sel), .core_base1_sel(core_base1_sel),
        .core_result_x(core_result_x), .core_result_y(core_result_y),
        .core_done(core_done), .core_ready(core_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_k(out_k), .out_x(out_x), .out_y(out_y)
    );

    // Radical inverse of k in the selected base, truncated to 16.16
    function automatic logic [31:0] halton(input logic [31:0] k, input logic [1:0] sel);
        longint unsigned n;
        longint unsigned b;
        real f;
        real r;
        b = (sel == 2'b00) ? 64'd2 : (sel == 2'b01) ? 64'd3 : 64'd7;
        n = 64'(k);
        f = 1.0;
        r = 0.0;
        while (n > 0) begin
            f = f / real'(b);
            r = r + f * real'(n % b);
            n = n / b;
        end
        return 32'($rtoi(r * 65536.0));
    endfunction

    function automatic logic [31:0] within_tol(input logic [31:0] a, input logic [31:0] b);
        return (((a > b) ? (a - b) : (b - a)) <= 32'h100) ? 32'd1 : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural Halton core ----------------
    int          lat_min = 1;
    int          lat_max = 3;
    logic        core_busy_m = 1'b0;
    logic        core_track_m = 1'b0;
    int          cnt_m = 0;
    logic [31:0] ck_m = 32'd0;
    logic [1:0]  cb0_m = 2'b00;
    logic [1:0]  cb1_m = 2'b00;
    int          start_cnt = 0;
    int          outst_viol = 0;
    int          kstable_viol = 0;
    logic [31:0] ck_log[$];

    always @(negedge clk) begin
        if (core_start) begin
            if (core_busy_m) outst_viol++;
            start_cnt++;
            ck_log.push_back(core_k);
            ck_m = core_k;
            cb0_m = core_base0_sel;
            cb1_m = core_base1_sel;
            core_busy_m = 1'b1;
            core_track_m = 1'b1;
            core_ready = 1'b0;
            core_done = 1'b0;
            cnt_m = int'($urandom_range(lat_max, lat_min));
        end else if (core_busy_m) begin
            if (rst) core_track_m = 1'b0;
            if (core_track_m && (core_k !== ck_m || core_base0_sel !== cb0_m ||
                                 core_base1_sel !== cb1_m)) kstable_viol++;
            cnt_m--;
            if (cnt_m <= 0) begin
                core_done = 1'b1;
                core_result_x = halton(ck_m, cb0_m);
                core_result_y = halton(ck_m, cb1_m);
                core_busy_m = 1'b0;
                core_ready = 1'b1;
            end
        end else begin
            core_done = 1'b0;
        end
    end

    // ---------------- stream consumer ----------------
    int   ready_mode = 1;
    int   stall_viol = 0;
    int   done_cnt = 0;
    logic held_v = 1'b0;
    pt_t  held_pt;
    logic rdy_v;
    pt_t  log_q[$];

    always @(negedge clk) begin
        if (seq_done) done_cnt++;
        if (rst) begin
            out_ready = 1'b0;
            held_v = 1'b0;
        end else begin
            if (held_v && (!out_valid || {out_k, out_x, out_y} !== held_pt)) stall_viol++;
            case (ready_mode)
                0:       rdy_v = 1'b0;
                1:       rdy_v = 1'b1;
                default: rdy_v = 1'($urandom_range(1, 0));
            endcase
            out_ready = rdy_v;
            if (out_valid && rdy_v) begin
                log_q.push_back({out_k, out_x, out_y});
                held_v = 1'b0;
            end else if (out_valid) begin
                held_v = 1'b1;
                held_pt = {out_k, out_x, out_y};
            end else begin
                held_v = 1'b0;
            end
        end
    end

    // ---------------- directed steps ----------------
    pt_t         exp_q[$];
    int          log_base;
    bit          ok;
    logic [31:0] spec_x [4] = '{32'h8000, 32'h4000, 32'hC000, 32'h2000};
    logic [31:0] spec_y [4] = '{32'h5555, 32'hAAAA, 32'h1C71, 32'h71C7};

    task automatic start_seq(input logic [31:0] ks, input logic [31:0] cnt,
                             input logic [1:0] b0, input logic [1:0] b1, input bit accept);
        logic [31:0] kk;
        @(negedge clk);
        cfg_k_start = ks;
        cfg_count = cnt;
        cfg_base0_sel = b0;
        cfg_base1_sel = b1;
        cfg_start = 1'b1;
        if (accept) begin
            exp_q.delete();
            log_base = log_q.size();
            for (longint i = 0; i < longint'(cnt); i++) begin
                kk = 32'((64'(ks) + 64'(i)) % 64'h1_0000_0000);
                exp_q.push_back({kk, halton(kk, b0), halton(kk, b1)});
            end
        end
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            #1;
            if (seq_done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_drain(input int bound, output bit drained);
        drained = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            #1;
            if ((log_q.size() - log_base) >= exp_q.size() && !out_valid) begin
                drained = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_points(input string tag);
        chk({tag, "_npoints"}, 32'(log_q.size() - log_base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && (log_base + i) < log_q.size(); i++) begin
            chk({tag, "_k"}, log_q[log_base + i].k, exp_q[i].k);
            chk({tag, "_x"}, log_q[log_base + i].x, exp_q[i].x);
            chk({tag, "_y"}, log_q[log_base + i].y, exp_q[i].y);
        end
    endtask

    task automatic run_seq(input string tag, input logic [31:0] ks, input logic [31:0] cnt,
                           input logic [1:0] b0, input logic [1:0] b1);
        int s0;
        s0 = start_cnt;
        start_seq(ks, cnt, b0, b1, 1'b1);
        wait_done(4000, ok);
        chk({tag, "_done_seen"}, {31'd0, ok}, 32'd1);
        wait_drain(4000, ok);
        chk({tag, "_drained"}, {31'd0, ok}, 32'd1);
        check_points(tag);
        chk({tag, "_starts"}, 32'(start_cnt - s0), cnt);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_seq_done"}, {31'd0, seq_done}, 32'd0);
        chk({tag, "_core_start"}, {31'd0, core_start}, 32'd0);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_core_k"}, core_k, 32'd0);
        chk({tag, "_core_bases"}, {28'd0, core_base0_sel, core_base1_sel}, 32'd0);
        chk({tag, "_out_k"}, out_k, 32'd0);
        chk({tag, "_out_x"}, out_x, 32'd0);
        chk({tag, "_out_y"}, out_y, 32'd0);
    endtask

    initial begin
        int s0, d0, p0;
        log_base = 0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic sequence against known Halton values
        ready_mode = 1;
        d0 = done_cnt;
        run_seq("basic", 32'd1, 32'd4, 2'b00, 2'b01);
        repeat (3) @(negedge clk);
        chk("basic_done_pulses", 32'(done_cnt - d0), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("basic_spec_k", log_q[log_base + i].k, 32'(i + 1));
            chk("basic_spec_x", within_tol(log_q[log_base + i].x, spec_x[i]), 32'd1);
            chk("basic_spec_y", within_tol(log_q[log_base + i].y, spec_y[i]), 32'd1);
        end

        // Back-pressure: four issues fill the buffer, then the driver stalls
        ready_mode = 0;
        s0 = start_cnt;
        start_seq(32'd5, 32'd10, 2'b01, 2'b10, 1'b1);
        repeat (60) @(negedge clk);
        #1;
        chk("bp_starts_at_stall", 32'(start_cnt - s0), 32'd4);
        chk("bp_busy", {31'd0, busy}, 32'd1);
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_head_k", out_k, 32'd5);
        repeat (20) @(negedge clk);
        chk("bp_starts_still", 32'(start_cnt - s0), 32'd4);
        ready_mode = 1;
        wait_done(1000, ok);
        chk("bp_done_seen", {31'd0, ok}, 32'd1);
        wait_drain(1000, ok);
        chk("bp_drained", {31'd0, ok}, 32'd1);
        check_points("bp");
        chk("bp_starts_total", 32'(start_cnt - s0), 32'd10);
        chk("bp_stall_stable", 32'(stall_viol), 32'd0);

        // Zero count: seq_done two cycles after cfg_start, nothing issued
        s0 = start_cnt;
        start_seq(32'd9, 32'd0, 2'b00, 2'b00, 1'b1);
        #1;
        chk("zero_done_c1", {31'd0, seq_done}, 32'd0);
        @(negedge clk);
        #1;
        chk("zero_done_c2", {31'd0, seq_done}, 32'd1);
        chk("zero_valid_c2", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        #1;
        chk("zero_done_c3", {31'd0, seq_done}, 32'd0);
        repeat (5) @(negedge clk);
        chk("zero_starts", 32'(start_cnt - s0), 32'd0);
        chk("zero_out_valid", {31'd0, out_valid}, 32'd0);

        // Index wrap around 2^32
        s0 = ck_log.size();
        run_seq("wrap", 32'hFFFF_FFFF, 32'd2, 2'b10, 2'b00);
        chk("wrap_core_k0", ck_log[s0], 32'hFFFF_FFFF);
        chk("wrap_core_k1", ck_log[s0 + 1], 32'h0000_0000);

        // cfg_start while busy is ignored
        s0 = start_cnt;
        start_seq(32'd20, 32'd3, 2'b01, 2'b01, 1'b1);
        @(negedge clk);
        #1;
        chk("ign_busy_before", {31'd0, busy}, 32'd1);
        start_seq(32'd100, 32'd7, 2'b00, 2'b10, 1'b0);
        wait_done(1000, ok);
        chk("ign_done_seen", {31'd0, ok}, 32'd1);
        wait_drain(1000, ok);
        check_points("ign");
        repeat (5) @(negedge clk);
        chk("ign_starts", 32'(start_cnt - s0), 32'd3);
        chk("ign_busy_after", {31'd0, busy}, 32'd0);

        // Reset while waiting on the core; the late core_done must be ignored
        lat_min = 8;
        lat_max = 8;
        s0 = start_cnt;
        start_seq(32'd50, 32'd5, 2'b00, 2'b01, 1'b1);
        for (int i = 0; i < 50 && start_cnt == s0; i++) @(negedge clk);
        chk("rst_issue_seen", 32'(start_cnt - s0), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        #2;
        rst = 1'b0;
        p0 = log_q.size();
        repeat (14) @(negedge clk);
        #1;
        chk("midrst_no_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_idle", {31'd0, busy}, 32'd0);
        chk("midrst_no_pops", 32'(log_q.size() - p0), 32'd0);
        lat_min = 1;
        lat_max = 3;
        run_seq("after_rst", 32'd1, 32'd1, 2'b01, 2'b10);
        chk("after_rst_x_spec", within_tol(log_q[log_base].x, 32'h5555), 32'd1);
        chk("after_rst_y_spec", within_tol(log_q[log_base].y, 32'h2492), 32'd1);

        // Random sequences with random back-pressure and core latency
        ready_mode = 2;
        lat_min = 1;
        lat_max = 5;
        for (int it = 0; it < 6; it++) begin
            logic [31:0] ks;
            ks = (it == 0) ? 32'hFFFF_FFF8 : $urandom;
            run_seq("rand", ks, 32'($urandom_range(12, 1)),
                    2'($urandom_range(2, 0)), 2'($urandom_range(2, 0)));
        end

        chk("one_outstanding", 32'(outst_viol), 32'd0);
        chk("core_inputs_stable", 32'(kstable_viol), 32'd0);
        chk("stall_stable_all", 32'(stall_viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
